// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the rename-to-issue dispatch stage.
// Optional stall counter is enabled with DISPATCH_PERF_CNT_EN.
package dispatch_pkg;

   localparam int PREG_NUM = 64;
   localparam int PREG_W   = $clog2(PREG_NUM);
   localparam int ROB_LOG  = 6;

   // Decode bundle carried opaquely through the stage; pads to exactly 128 bits.
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] imm;
      logic [7:0]  cx_type;
      logic [7:0]  alu_type;
      logic [3:0]  muldiv_type;
      logic        is_word;
      logic        is_imm;
      logic        is_load;
      logic        is_store;
      logic        is_unsigned;
      logic [1:0]  ls_size;
      logic [4:0]  rsvd;
   } dispatch_ctrl_t;

   localparam int CTRL_W = $bits(dispatch_ctrl_t);

   // True when either writeback port wakes up physical register p this cycle.
   function automatic logic wbhit(
      input logic              wb0_valid,
      input logic              wb0_need_to_wb,
      input logic [PREG_W-1:0] wb0_prd,
      input logic              wb1_valid,
      input logic              wb1_need_to_wb,
      input logic [PREG_W-1:0] wb1_prd,
      input logic [PREG_W-1:0] p
   );
      return (wb0_valid & wb0_need_to_wb & (wb0_prd == p)) |
             (wb1_valid & wb1_need_to_wb & (wb1_prd == p));
   endfunction

endpackage

// File: rtl/dispatch_stage_busy_table.sv
// Physical-register busy bits: two bypassed read ports, one set port, two clear ports.
// Register 0 is hard-wired not busy; a set and a clear of the same register resolve to set.
module busy_table
   import dispatch_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic [PREG_W-1:0] rd0_prs_i,
   input  logic [PREG_W-1:0] rd1_prs_i,
   output logic              rd0_busy_o,
   output logic              rd1_busy_o,
   input  logic              set_valid_i,
   input  logic [PREG_W-1:0] set_prd_i,
   input  logic              clr0_valid_i,
   input  logic [PREG_W-1:0] clr0_prd_i,
   input  logic              clr1_valid_i,
   input  logic [PREG_W-1:0] clr1_prd_i
);

   logic [PREG_NUM-1:0] busy_q;
   logic [PREG_NUM-1:0] busy_d;
   logic                rd0Hit;
   logic                rd1Hit;

   assign rd0Hit = (clr0_valid_i & (clr0_prd_i == rd0_prs_i)) |
                   (clr1_valid_i & (clr1_prd_i == rd0_prs_i));
   assign rd1Hit = (clr0_valid_i & (clr0_prd_i == rd1_prs_i)) |
                   (clr1_valid_i & (clr1_prd_i == rd1_prs_i));

   assign rd0_busy_o = busy_q[rd0_prs_i] & ~rd0Hit;
   assign rd1_busy_o = busy_q[rd1_prs_i] & ~rd1Hit;

   // Clears are applied before the set so a same-cycle reallocation stays busy.
   always_comb begin
      busy_d = busy_q;
      if (clr0_valid_i) begin
         busy_d[clr0_prd_i] = 1'b0;
      end
      if (clr1_valid_i) begin
         busy_d[clr1_prd_i] = 1'b0;
      end
      if (set_valid_i) begin
         busy_d[set_prd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/dispatch_stage.sv
// Single-entry register stage from rename into the integer issue queue, owning the busy table.
// Define DISPATCH_PERF_CNT_EN to build the saturating perf_stall_cnt output.
module dispatch_stage
   import dispatch_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PREG_W-1:0]  in_prs1,
   input  logic [PREG_W-1:0]  in_prs2,
   input  logic [PREG_W-1:0]  in_prd,
   input  logic               in_src1_is_reg,
   input  logic               in_src2_is_reg,
   input  logic               in_need_to_wb,
   input  logic               in_robidx_flag,
   input  logic [ROB_LOG-1:0] in_robidx,
   input  logic [CTRL_W-1:0]  in_ctrl,
   output logic               enq_valid,
   input  logic               enq_ready,
   output logic [PREG_W-1:0]  enq_prs1,
   output logic [PREG_W-1:0]  enq_prs2,
   output logic [PREG_W-1:0]  enq_prd,
   output logic               enq_src1_is_reg,
   output logic               enq_src2_is_reg,
   output logic               enq_need_to_wb,
   output logic               enq_robidx_flag,
   output logic [ROB_LOG-1:0] enq_robidx,
   output logic [CTRL_W-1:0]  enq_ctrl,
   output logic               enq_src1_state,
   output logic               enq_src2_state,
   input  logic               wb0_valid,
   input  logic               wb0_need_to_wb,
   input  logic [PREG_W-1:0]  wb0_prd,
   input  logic               wb1_valid,
   input  logic               wb1_need_to_wb,
   input  logic [PREG_W-1:0]  wb1_prd,
   input  logic               flush_valid,
   input  logic               flush_robidx_flag,
   input  logic [ROB_LOG-1:0] flush_robidx
`ifdef DISPATCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_stall_cnt
`endif
);

   logic               held_q, held_d;
   logic [PREG_W-1:0]  prs1_q, prs1_d;
   logic [PREG_W-1:0]  prs2_q, prs2_d;
   logic [PREG_W-1:0]  prd_q, prd_d;
   logic               src1IsReg_q, src1IsReg_d;
   logic               src2IsReg_q, src2IsReg_d;
   logic               needToWb_q, needToWb_d;
   logic               robFlag_q, robFlag_d;
   logic [ROB_LOG-1:0] robIdx_q, robIdx_d;
   dispatch_ctrl_t     ctrl_q, ctrl_d;
   logic               state1_q, state1_d;
   logic               state2_q, state2_d;

   logic capture;
   logic flushKill;
   logic rdBusy1;
   logic rdBusy2;
   logic wbHitHeld1;
   logic wbHitHeld2;
   logic wb0Clr;
   logic wb1Clr;

   assign wb0Clr = wb0_valid & wb0_need_to_wb & (wb0_prd != '0);
   assign wb1Clr = wb1_valid & wb1_need_to_wb & (wb1_prd != '0);

   busy_table u_busy_table (
      .clock        (clock),
      .reset_n      (reset_n),
      .rd0_prs_i    (in_prs1),
      .rd1_prs_i    (in_prs2),
      .rd0_busy_o   (rdBusy1),
      .rd1_busy_o   (rdBusy2),
      .set_valid_i  (capture & in_need_to_wb & (in_prd != '0)),
      .set_prd_i    (in_prd),
      .clr0_valid_i (wb0Clr),
      .clr0_prd_i   (wb0_prd),
      .clr1_valid_i (wb1Clr),
      .clr1_prd_i   (wb1_prd)
   );

   assign wbHitHeld1 = wbhit(wb0_valid, wb0_need_to_wb, wb0_prd,
                             wb1_valid, wb1_need_to_wb, wb1_prd, prs1_q);
   assign wbHitHeld2 = wbhit(wb0_valid, wb0_need_to_wb, wb0_prd,
                             wb1_valid, wb1_need_to_wb, wb1_prd, prs2_q);

   // Flag mismatch means the ROB index has wrapped, which inverts the age comparison.
   assign flushKill = flush_valid & held_q &
                      ((flush_robidx_flag ^ robFlag_q) ^ (flush_robidx < robIdx_q));

   assign in_ready  = ~flush_valid & (~held_q | enq_ready);
   assign capture   = in_valid & in_ready;
   assign enq_valid = held_q & ~flushKill;

   assign enq_prs1        = prs1_q;
   assign enq_prs2        = prs2_q;
   assign enq_prd         = prd_q;
   assign enq_src1_is_reg = src1IsReg_q;
   assign enq_src2_is_reg = src2IsReg_q;
   assign enq_need_to_wb  = needToWb_q;
   assign enq_robidx_flag = robFlag_q;
   assign enq_robidx      = robIdx_q;
   assign enq_ctrl        = ctrl_q;
   assign enq_src1_state  = state1_q & ~wbHitHeld1;
   assign enq_src2_state  = state2_q & ~wbHitHeld2;

   always_comb begin
      held_d = held_q;
      if (capture) begin
         held_d = 1'b1;
      end else if (flushKill || (enq_valid && enq_ready)) begin
         held_d = 1'b0;
      end
   end

   // Held source states keep absorbing wakeups so the issue queue sees them cleared.
   always_comb begin
      prs1_d      = prs1_q;
      prs2_d      = prs2_q;
      prd_d       = prd_q;
      src1IsReg_d = src1IsReg_q;
      src2IsReg_d = src2IsReg_q;
      needToWb_d  = needToWb_q;
      robFlag_d   = robFlag_q;
      robIdx_d    = robIdx_q;
      ctrl_d      = ctrl_q;
      state1_d    = state1_q & ~wbHitHeld1;
      state2_d    = state2_q & ~wbHitHeld2;
      if (capture) begin
         prs1_d      = in_prs1;
         prs2_d      = in_prs2;
         prd_d       = in_prd;
         src1IsReg_d = in_src1_is_reg;
         src2IsReg_d = in_src2_is_reg;
         needToWb_d  = in_need_to_wb;
         robFlag_d   = in_robidx_flag;
         robIdx_d    = in_robidx;
         ctrl_d      = dispatch_ctrl_t'(in_ctrl);
         state1_d    = rdBusy1 & in_src1_is_reg;
         state2_d    = rdBusy2 & in_src2_is_reg;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         held_q <= 1'b0;
      end else begin
         held_q <= held_d;
      end
   end

   // Payload is only meaningful while held_q is set, so it needs no reset.
   always_ff @(posedge clock) begin
      prs1_q      <= prs1_d;
      prs2_q      <= prs2_d;
      prd_q       <= prd_d;
      src1IsReg_q <= src1IsReg_d;
      src2IsReg_q <= src2IsReg_d;
      needToWb_q  <= needToWb_d;
      robFlag_q   <= robFlag_d;
      robIdx_q    <= robIdx_d;
      ctrl_q      <= ctrl_d;
      state1_q    <= state1_d;
      state2_q    <= state2_d;
   end

`ifdef DISPATCH_PERF_CNT_EN
   logic [31:0] stallCnt_q;
   logic [31:0] stallCnt_d;

   always_comb begin
      stallCnt_d = stallCnt_q;
      if (held_q && !enq_ready && (stallCnt_q != 32'hFFFF_FFFF)) begin
         stallCnt_d = stallCnt_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stallCnt_q <= '0;
      end else begin
         stallCnt_q <= stallCnt_d;
      end
   end

   assign perf_stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage: expected enqueues are queued at capture and checked on handshake.
// Set DISPATCH_PERF_CNT_EN to also check the stall counter.
module tb_dispatch_stage;
   import dispatch_pkg::*;

   logic               clock = 1'b0;
   logic               reset_n;
   logic               in_valid;
   logic               in_ready;
   logic [PREG_W-1:0]  in_prs1, in_prs2, in_prd;
   logic               in_src1_is_reg, in_src2_is_reg, in_need_to_wb;
   logic               in_robidx_flag;
   logic [ROB_LOG-1:0] in_robidx;
   logic [CTRL_W-1:0]  in_ctrl;
   logic               enq_valid, enq_ready;
   logic [PREG_W-1:0]  enq_prs1, enq_prs2, enq_prd;
   logic               enq_src1_is_reg, enq_src2_is_reg, enq_need_to_wb;
   logic               enq_robidx_flag;
   logic [ROB_LOG-1:0] enq_robidx;
   logic [CTRL_W-1:0]  enq_ctrl;
   logic               enq_src1_state, enq_src2_state;
   logic               wb0_valid, wb0_need_to_wb, wb1_valid, wb1_need_to_wb;
   logic [PREG_W-1:0]  wb0_prd, wb1_prd;
   logic               flush_valid, flush_robidx_flag;
   logic [ROB_LOG-1:0] flush_robidx;
`ifdef DISPATCH_PERF_CNT_EN
   logic [31:0]        perf_stall_cnt;
`endif

   typedef struct packed {
      logic [PREG_W-1:0]  prs1;
      logic [PREG_W-1:0]  prs2;
      logic [PREG_W-1:0]  prd;
      logic               is1;
      logic               is2;
      logic               need;
      logic               flag;
      logic [ROB_LOG-1:0] idx;
      logic [CTRL_W-1:0]  ctrl;
      logic               s1;
      logic               s2;
   } exp_t;

   exp_t expQ[$];
   exp_t popped;
   int   vectors = 0;
   int   miscompares = 0;
   logic monitorOn = 1'b0;

   dispatch_stage dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_prs1           (in_prs1),
      .in_prs2           (in_prs2),
      .in_prd            (in_prd),
      .in_src1_is_reg    (in_src1_is_reg),
      .in_src2_is_reg    (in_src2_is_reg),
      .in_need_to_wb     (in_need_to_wb),
      .in_robidx_flag    (in_robidx_flag),
      .in_robidx         (in_robidx),
      .in_ctrl           (in_ctrl),
      .enq_valid         (enq_valid),
      .enq_ready         (enq_ready),
      .enq_prs1          (enq_prs1),
      .enq_prs2          (enq_prs2),
      .enq_prd           (enq_prd),
      .enq_src1_is_reg   (enq_src1_is_reg),
      .enq_src2_is_reg   (enq_src2_is_reg),
      .enq_need_to_wb    (enq_need_to_wb),
      .enq_robidx_flag   (enq_robidx_flag),
      .enq_robidx        (enq_robidx),
      .enq_ctrl          (enq_ctrl),
      .enq_src1_state    (enq_src1_state),
      .enq_src2_state    (enq_src2_state),
      .wb0_valid         (wb0_valid),
      .wb0_need_to_wb    (wb0_need_to_wb),
      .wb0_prd           (wb0_prd),
      .wb1_valid         (wb1_valid),
      .wb1_need_to_wb    (wb1_need_to_wb),
      .wb1_prd           (wb1_prd),
      .flush_valid       (flush_valid),
      .flush_robidx_flag (flush_robidx_flag),
      .flush_robidx      (flush_robidx)
`ifdef DISPATCH_PERF_CNT_EN
      ,
      .perf_stall_cnt    (perf_stall_cnt)
`endif
   );

   always #5 clock = ~clock;

   // Hard bound on run time so a stuck design still terminates.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives one rename beat; when push is set the enqueue expected at handshake is queued.
   task automatic applyStimulus(input int prs1, input int prs2, input int prd,
                                input int is1, input int is2, input int need,
                                input int flag, input int idx,
                                input int s1, input int s2, input bit push);
      exp_t e;
      in_valid       = 1'b1;
      in_prs1        = PREG_W'(prs1);
      in_prs2        = PREG_W'(prs2);
      in_prd         = PREG_W'(prd);
      in_src1_is_reg = 1'(is1);
      in_src2_is_reg = 1'(is2);
      in_need_to_wb  = 1'(need);
      in_robidx_flag = 1'(flag);
      in_robidx      = ROB_LOG'(idx);
      in_ctrl        = {$urandom, $urandom, $urandom, $urandom};
      if (push) begin
         e.prs1 = in_prs1;
         e.prs2 = in_prs2;
         e.prd  = in_prd;
         e.is1  = in_src1_is_reg;
         e.is2  = in_src2_is_reg;
         e.need = in_need_to_wb;
         e.flag = in_robidx_flag;
         e.idx  = in_robidx;
         e.ctrl = in_ctrl;
         e.s1   = 1'(s1);
         e.s2   = 1'(s2);
         expQ.push_back(e);
      end
   endtask

   task automatic setWb(input int port, input int valid, input int need, input int prd);
      if (port == 0) begin
         wb0_valid = 1'(valid); wb0_need_to_wb = 1'(need); wb0_prd = PREG_W'(prd);
      end else begin
         wb1_valid = 1'(valid); wb1_need_to_wb = 1'(need); wb1_prd = PREG_W'(prd);
      end
   endtask

   task automatic setFlush(input int valid, input int flag, input int idx);
      flush_valid = 1'(valid); flush_robidx_flag = 1'(flag); flush_robidx = ROB_LOG'(idx);
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   // Every accepted enqueue must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (monitorOn && reset_n && enq_valid && enq_ready) begin
         if (expQ.size() == 0) begin
            checkBit("unexpected_enq", 1'b1, 1'b0);
         end else begin
            popped = expQ.pop_front();
            checkOutput("enq_payload",
               256'({enq_prs1, enq_prs2, enq_prd, enq_src1_is_reg, enq_src2_is_reg,
                     enq_need_to_wb, enq_robidx_flag, enq_robidx, enq_ctrl}),
               256'({popped.prs1, popped.prs2, popped.prd, popped.is1, popped.is2,
                     popped.need, popped.flag, popped.idx, popped.ctrl}));
            checkOutput("enq_state", 256'({enq_src1_state, enq_src2_state}),
                        256'({popped.s1, popped.s2}));
         end
      end
   end

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_prs1 = '0; in_prs2 = '0; in_prd = '0;
      in_src1_is_reg = 1'b0; in_src2_is_reg = 1'b0; in_need_to_wb = 1'b0;
      in_robidx_flag = 1'b0; in_robidx = '0; in_ctrl = '0;
      enq_ready = 1'b1;
      setWb(0, 0, 0, 0);
      setWb(1, 0, 0, 0);
      setFlush(0, 0, 0);

      @(negedge clock);
      checkBit("reset_enq_valid", enq_valid, 1'b0);
      checkBit("reset_in_ready", in_ready, 1'b1);
`ifdef DISPATCH_PERF_CNT_EN
      checkOutput("reset_perf", 256'(perf_stall_cnt), 256'(0));
`endif
      nextCycle();
      reset_n   = 1'b1;
      monitorOn = 1'b1;

      // Capture of a free source, enqueue one cycle later.
      applyStimulus(5, 0, 3, 1, 0, 1, 0, 1, 0, 0, 1);
      @(negedge clock);
      checkBit("t1_in_ready", in_ready, 1'b1);
      checkBit("t1_no_early_enq", enq_valid, 1'b0);
      nextCycle();
      in_valid = 1'b0;
      @(negedge clock);
      checkBit("t1_enq_valid", enq_valid, 1'b1);
      nextCycle();

      // Producer A then consumer B; wakeup arrives while B is stalled.
      applyStimulus(0, 0, 7, 0, 0, 1, 0, 2, 0, 0, 1);
      @(negedge clock);
      nextCycle();
      applyStimulus(7, 0, 8, 1, 0, 1, 0, 3, 0, 0, 1);
      @(negedge clock);
      checkBit("t2_back_to_back_ready", in_ready, 1'b1);
      nextCycle();
      in_valid  = 1'b0;
      enq_ready = 1'b0;
      @(negedge clock);
      checkBit("t2_b_busy", enq_src1_state, 1'b1);
      checkBit("t2_stall_in_ready", in_ready, 1'b0);
      nextCycle();
      setWb(0, 1, 1, 7);
      @(negedge clock);
      checkBit("t2_wb_bypass_out", enq_src1_state, 1'b0);
      nextCycle();
      setWb(0, 0, 0, 0);
      enq_ready = 1'b1;
      @(negedge clock);
      nextCycle();

      // Capture-time bypass of wb1 and the resulting busy-table clear.
      applyStimulus(0, 0, 9, 0, 0, 1, 0, 4, 0, 0, 1);
      @(negedge clock);
      nextCycle();
      applyStimulus(0, 9, 10, 0, 1, 1, 0, 5, 0, 0, 1);
      setWb(1, 1, 1, 9);
      @(negedge clock);
      nextCycle();
      setWb(1, 0, 0, 0);
      applyStimulus(8, 9, 11, 1, 1, 0, 0, 6, 1, 0, 1);
      setWb(0, 1, 0, 8);
      @(negedge clock);
      nextCycle();
      setWb(0, 0, 0, 0);
      applyStimulus(8, 0, 0, 0, 0, 0, 0, 7, 0, 0, 1);
      @(negedge clock);
      nextCycle();
      in_valid = 1'b0;
      @(negedge clock);
      nextCycle();

      // Asynchronous reset with an entry held; busy bits must clear too.
      applyStimulus(8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      enq_ready = 1'b0;
      @(negedge clock);
      nextCycle();
      in_valid = 1'b0;
      @(negedge clock);
      checkBit("pre_reset_held", enq_valid, 1'b1);
      #1;
      reset_n = 1'b0;
      #1;
      checkBit("async_reset_enq_valid", enq_valid, 1'b0);
      nextCycle();
      reset_n   = 1'b1;
      enq_ready = 1'b1;
      applyStimulus(8, 10, 0, 1, 1, 0, 0, 8, 0, 0, 1);
      @(negedge clock);
      nextCycle();

      // Three-cycle stall: payload steady, input refused, single enqueue on release.
      applyStimulus(3, 0, 13, 1, 0, 1, 0, 9, 0, 0, 1);
      @(negedge clock);
      nextCycle();
      applyStimulus(13, 0, 14, 1, 0, 1, 0, 10, 1, 0, 1);
      enq_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checkBit("t4_stall_enq_valid", enq_valid, 1'b1);
         checkBit("t4_stall_in_ready", in_ready, 1'b0);
         checkOutput("t4_stall_payload", 256'({enq_prd, enq_robidx}), 256'({6'd13, 6'd9}));
         nextCycle();
      end
      enq_ready = 1'b1;
      @(negedge clock);
      checkBit("t4_release_in_ready", in_ready, 1'b1);
`ifdef DISPATCH_PERF_CNT_EN
      checkOutput("t4_perf_stall_cnt", 256'(perf_stall_cnt), 256'(3));
`endif
      nextCycle();
      in_valid = 1'b0;
      @(negedge clock);
      nextCycle();

      // Flush of a younger entry, survival of an older one, and the wrapped-flag case.
      applyStimulus(1, 2, 3, 0, 0, 0, 1, 4, 0, 0, 0);
      @(negedge clock);
      nextCycle();
      applyStimulus(4, 5, 6, 0, 0, 0, 1, 5, 0, 0, 0);
      setFlush(1, 1, 2);
      @(negedge clock);
      checkBit("t5_flush_kill_enq", enq_valid, 1'b0);
      checkBit("t5_flush_in_ready", in_ready, 1'b0);
      nextCycle();
      in_valid = 1'b0;
      setFlush(0, 0, 0);
      @(negedge clock);
      checkBit("t5_entry_dropped", enq_valid, 1'b0);
      nextCycle();
      applyStimulus(20, 21, 22, 1, 1, 1, 1, 1, 0, 0, 1);
      @(negedge clock);
      nextCycle();
      in_valid = 1'b0;
      setFlush(1, 1, 2);
      @(negedge clock);
      checkBit("t5_older_kept", enq_valid, 1'b1);
      nextCycle();
      setFlush(0, 0, 0);
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      @(negedge clock);
      nextCycle();
      in_valid = 1'b0;
      setFlush(1, 1, 2);
      @(negedge clock);
      checkBit("t5_wrap_kill", enq_valid, 1'b0);
      nextCycle();
      setFlush(0, 0, 0);
      @(negedge clock);
      checkBit("t5_wrap_dropped", enq_valid, 1'b0);
      nextCycle();

      // prd 0 never busy; set and clear of prd 12 together leaves it busy.
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 11, 0, 0, 1);
      @(negedge clock);
      nextCycle();
      applyStimulus(0, 0, 12, 1, 1, 1, 0, 12, 0, 0, 1);
      setWb(0, 1, 1, 12);
      setWb(1, 1, 1, 0);
      @(negedge clock);
      nextCycle();
      setWb(0, 0, 0, 0);
      setWb(1, 0, 0, 0);
      applyStimulus(12, 0, 0, 1, 0, 0, 0, 13, 1, 0, 1);
      @(negedge clock);
      nextCycle();
      in_valid = 1'b0;
      @(negedge clock);
      nextCycle();
      @(negedge clock);
      checkBit("final_idle", enq_valid, 1'b0);
      checkOutput("queue_drained", 256'(expQ.size()), 256'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
